vedic_divider: RTL and testbench

//  Iterative radix-2 restoring unsigned divider; the inverse of the team's vedic multiplier arrays.

---
 rtl/vedic_div_pkg.sv | 18 +
 rtl/vedic_divider_if.sv | 24 ++
 rtl/vedic_div_step.sv | 27 ++
 rtl/vedic_divider.sv | 130 +++++++++++++
 tb/tb_vedic_divider.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vedic_div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package vedic_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // Iteration counter width for a given operand width; it must hold WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/vedic_divider_if.sv
// Operand/result handshake bundle for vedic_divider.
interface vedic_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/vedic_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, subtract the
// divisor if it fits. The shifted partial remainder is WIDTH+1 bits so the
// compare never overflows; the stored remainder always fits in WIDTH bits.
module vedic_div_step
  import vedic_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] r_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Compare and conditional subtract; diff is only used when it is exact.
  always_comb begin
    shifted = {r_i, bit_i};
    diff    = shifted[WIDTH-1:0] - divisor_i;
    q_bit_o = (shifted >= {1'b0, divisor_i});
    r_o     = q_bit_o ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/vedic_divider.sv
// Iterative radix-2 restoring unsigned divider with valid/ready handshakes.
// Optional build macro: VEDIC_DIV_ZERO_SHORTCUT_EN -- a zero divisor skips
// the iterations and reports the all-ones/dividend result immediately.
module vedic_divider
  import vedic_div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  vedic_divider_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] step_r;
  logic             step_q;

  vedic_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i       (r_q),
    .bit_i     (a_q[WIDTH-1]),
    .divisor_i (b_q),
    .r_o       (step_r),
    .q_bit_o   (step_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; in_ready is high throughout IDLE so in_valid accepts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef VEDIC_DIV_ZERO_SHORTCUT_EN
          state_d = (bus.divisor == '0) ? DONE : BUSY;
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and handshake next values.
  always_comb begin
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    q_d         = q_q;
    r_d         = r_q;
    dz_d        = dz_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d   = bus.dividend;
          b_d   = bus.divisor;
          q_d   = '0;
          r_d   = '0;
          cnt_d = CNT_W'(WIDTH - 1);
          dz_d  = (bus.divisor == '0);
`ifdef VEDIC_DIV_ZERO_SHORTCUT_EN
          if (bus.divisor == '0) begin
            q_d = '1;
            r_d = bus.dividend;
          end
`endif
        end
      end
      BUSY: begin
        a_d = {a_q[WIDTH-2:0], 1'b0};
        q_d = {q_q[WIDTH-2:0], step_q};
        r_d = step_r;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      q_q         <= q_d;
      r_q         <= r_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_vedic_divider.sv
// Scoreboard bench for vedic_divider (WIDTH=8), directed plus random traffic.
module tb_vedic_divider;

  localparam int unsigned W = 8;
  localparam int STD_LAT = W + 1;
`ifdef VEDIC_DIV_ZERO_SHORTCUT_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = W + 1;
`endif

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vedic_divider_if #(.WIDTH(W)) vif ();

  vedic_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t sb[$];

  logic [W-1:0] basic_a [5] = '{8'd200, 8'd255, 8'd5, 8'd0, 8'd255};
  logic [W-1:0] basic_b [5] = '{8'd7,   8'd1,   8'd9, 8'd3, 8'd255};

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Drive one operation with out_ready high; return observed result and the
  // number of rising edges from the handshake edge to out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output res_t obs, output int lat);
    int n;
    sb.push_back(model(a, b));
    @(negedge clk);
    vif.dividend  = a;
    vif.divisor   = b;
    vif.in_valid  = 1'b1;
    vif.out_ready = 1'b1;
    n = 0;
    while (vif.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    vif.in_valid = 1'b0;
    while (vif.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    obs.q  = vif.quotient;
    obs.r  = vif.remainder;
    obs.dz = vif.div_by_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (vif.in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", vif.in_ready); end
    n_checks++; if (vif.out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", vif.out_valid); end
    n_checks++; if (vif.quotient !== 8'd0)    begin n_fail++; $display("FAIL reset_quotient: got %0d want 0", vif.quotient); end
    n_checks++; if (vif.remainder !== 8'd0)   begin n_fail++; $display("FAIL reset_remainder: got %0d want 0", vif.remainder); end
    n_checks++; if (vif.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", vif.div_by_zero); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    res_t obs, exp;
    int   lat;
    for (int i = 0; i < 5; i++) begin
      run_op(basic_a[i], basic_b[i], obs, lat);
      exp = sb.pop_front();
      n_checks++; if (obs.q !== exp.q)   begin n_fail++; $display("FAIL basic_q %0d/%0d: got %0d want %0d", basic_a[i], basic_b[i], obs.q, exp.q); end
      n_checks++; if (obs.r !== exp.r)   begin n_fail++; $display("FAIL basic_r %0d/%0d: got %0d want %0d", basic_a[i], basic_b[i], obs.r, exp.r); end
      n_checks++; if (obs.dz !== exp.dz) begin n_fail++; $display("FAIL basic_dz %0d/%0d: got %b want %b", basic_a[i], basic_b[i], obs.dz, exp.dz); end
      n_checks++; if (lat != STD_LAT)    begin n_fail++; $display("FAIL basic_latency %0d/%0d: got %0d want %0d", basic_a[i], basic_b[i], lat, STD_LAT); end
    end
  endtask

  task automatic test_div_zero();
    res_t obs, exp;
    int   lat;
    logic [W-1:0] a;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 8'd13 : 8'd0;
      run_op(a, 8'd0, obs, lat);
      exp = sb.pop_front();
      n_checks++; if (obs.q !== exp.q)   begin n_fail++; $display("FAIL dz_q %0d/0: got %0d want %0d", a, obs.q, exp.q); end
      n_checks++; if (obs.r !== exp.r)   begin n_fail++; $display("FAIL dz_r %0d/0: got %0d want %0d", a, obs.r, exp.r); end
      n_checks++; if (obs.dz !== exp.dz) begin n_fail++; $display("FAIL dz_flag %0d/0: got %b want %b", a, obs.dz, exp.dz); end
      n_checks++; if (lat != ZERO_LAT)   begin n_fail++; $display("FAIL dz_latency %0d/0: got %0d want %0d", a, lat, ZERO_LAT); end
    end
  endtask

  task automatic test_backpressure();
    res_t exp;
    int   n;
    sb.push_back(model(8'd77, 8'd6));
    @(negedge clk);
    vif.out_ready = 1'b0;
    vif.dividend  = 8'd77;
    vif.divisor   = 8'd6;
    vif.in_valid  = 1'b1;
    n = 0;
    while (vif.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    vif.in_valid = 1'b0;
    n = 0;
    while (vif.out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_checks++; if (n >= 100) begin n_fail++; $display("FAIL bp_timeout: out_valid never rose"); end
    exp = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (vif.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc%0d: got %b want 1", k, vif.out_valid); end
      n_checks++; if (vif.in_ready !== 1'b0)  begin n_fail++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", k, vif.in_ready); end
      n_checks++;
      if ({vif.quotient, vif.remainder, vif.div_by_zero} !== exp) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                 k, vif.quotient, vif.remainder, vif.div_by_zero, exp.q, exp.r, exp.dz);
      end
      vif.in_valid = (k % 2 == 0);
      vif.dividend = 8'(k * 31 + 3);
      vif.divisor  = 8'(k + 1);
      @(negedge clk);
    end
    vif.in_valid  = 1'b0;
    vif.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (vif.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", vif.out_valid); end
    n_checks++; if (vif.in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", vif.in_ready); end
    repeat (12) @(negedge clk);
    n_checks++; if (vif.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ghost_op: got out_valid=%b want 0", vif.out_valid); end
  endtask

  task automatic test_reset_mid();
    res_t obs, exp;
    int   lat, n;
    @(negedge clk);
    vif.dividend = 8'd250;
    vif.divisor  = 8'd3;
    vif.in_valid = 1'b1;
    n = 0;
    while (vif.in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    vif.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (vif.in_ready !== 1'b1)    begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", vif.in_ready); end
    n_checks++; if (vif.out_valid !== 1'b0)   begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", vif.out_valid); end
    n_checks++; if (vif.quotient !== 8'd0)    begin n_fail++; $display("FAIL midrst_quotient: got %0d want 0", vif.quotient); end
    n_checks++; if (vif.remainder !== 8'd0)   begin n_fail++; $display("FAIL midrst_remainder: got %0d want 0", vif.remainder); end
    n_checks++; if (vif.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL midrst_dz: got %b want 0", vif.div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd100, 8'd10, obs, lat);
    exp = sb.pop_front();
    n_checks++; if (obs.q !== exp.q)   begin n_fail++; $display("FAIL midrst_after_q: got %0d want %0d", obs.q, exp.q); end
    n_checks++; if (obs.r !== exp.r)   begin n_fail++; $display("FAIL midrst_after_r: got %0d want %0d", obs.r, exp.r); end
    n_checks++; if (lat != STD_LAT)    begin n_fail++; $display("FAIL midrst_after_latency: got %0d want %0d", lat, STD_LAT); end
  endtask

  task automatic test_random();
    int rcv = 0;
    int cyc = 0;
    fork
      begin : producer
        logic [W-1:0] a, b;
        int guard;
        for (int i = 0; i < 2000; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          a = 8'($urandom);
          case ($urandom_range(0, 9))
            0:       b = 8'd0;
            1, 2, 3: b = 8'($urandom_range(1, 15));
            default: b = 8'($urandom);
          endcase
          vif.dividend = a;
          vif.divisor  = b;
          vif.in_valid = 1'b1;
          guard = 0;
          while (vif.in_ready !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
          if (guard >= 1000) begin
            n_checks++; n_fail++;
            $display("FAIL rand_accept_timeout op%0d", i);
          end else begin
            sb.push_back(model(a, b));
          end
          @(negedge clk);
          vif.in_valid = 1'b0;
        end
      end
      begin : consumer
        res_t exp;
        while (rcv < 2000 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          vif.out_ready = ($urandom_range(0, 3) != 0);
          if (vif.out_valid === 1'b1 && vif.out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
              n_fail++;
              $display("FAIL rand_unexpected: result q=%0d with empty scoreboard", vif.quotient);
            end else begin
              exp = sb.pop_front();
              if ({vif.quotient, vif.remainder, vif.div_by_zero} !== exp) begin
                n_fail++;
                $display("FAIL rand_result #%0d: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                         rcv, vif.quotient, vif.remainder, vif.div_by_zero, exp.q, exp.r, exp.dz);
              end
            end
            rcv++;
          end
        end
        n_checks++;
        if (rcv < 2000) begin
          n_fail++;
          $display("FAIL rand_timeout: got %0d results want 2000", rcv);
        end
      end
    join
    vif.out_ready = 1'b1;
    vif.in_valid  = 1'b0;
  endtask

  initial begin
    vif.in_valid  = 1'b0;
    vif.dividend  = '0;
    vif.divisor   = '0;
    vif.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
